// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates core and debug writes into one register-file write port with starvation guard and PC protection
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int REGS         = 16,
  parameter int ADDR_W       = $clog2(REGS),
  parameter int PC_REG       = REGS - 1,
  parameter int STARVE_LIMIT = 4,
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              core_valid,
  input  logic [ADDR_W-1:0] core_reg,
  input  logic [DATA_W-1:0] core_data,
  output logic              core_ready,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_reg,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              pc_write_err,
  output logic [SW-1:0]     starve_cnt
);
  logic [SW-1:0]     r_cnt;
  logic              r_wen;
  logic              r_err;
  logic [ADDR_W-1:0] r_reg;
  logic [DATA_W-1:0] r_data;
  logic              w_lim;
  logic              w_acc;
  logic              w_pc;
  logic [ADDR_W-1:0] w_reg;
  logic [DATA_W-1:0] w_data;
  logic [SW-1:0]     w_cnt_nxt;
  assign w_lim      = r_cnt == SW'(STARVE_LIMIT);
  // Core wins contention until the limit is reached; readies are forced low during reset.
  assign core_ready = rst_n & ~hold & core_valid & ~(dbg_valid & w_lim);
  assign dbg_ready  = rst_n & ~hold & dbg_valid & (~core_valid | w_lim);
  assign w_acc      = core_ready | dbg_ready;
  assign w_reg      = dbg_ready ? dbg_reg : core_reg;
  assign w_data     = dbg_ready ? dbg_data : core_data;
  assign w_pc       = w_reg == ADDR_W'(PC_REG);
  // A core grant while debug waits can only occur below the limit, so it increments.
  assign w_cnt_nxt  = hold ? r_cnt : (core_ready & dbg_valid) ? r_cnt + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wen  <= 1'b0;
      r_err  <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_wen <= w_acc & ~w_pc;
      r_err <= w_acc & w_pc;
      if (w_acc & ~w_pc) begin
        r_reg  <= w_reg;
        r_data <= w_data;
      end
    end
  assign rf_write_en   = r_wen;
  assign rf_write_reg  = r_reg;
  assign rf_write_data = r_data;
  assign pc_write_err  = r_err;
  assign starve_cnt    = r_cnt;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and randomized checks of regfile_write_arbiter against a behavioural model
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        core_valid;
  logic [3:0]  core_reg;
  logic [31:0] core_data;
  logic        core_ready;
  logic        dbg_valid;
  logic [3:0]  dbg_reg;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        rf_write_en;
  logic [3:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        pc_write_err;
  logic [2:0]  starve_cnt;
  int checks = 0;
  int errors = 0;
  int m_cnt;
  bit m_known;
  logic [3:0]  m_reg;
  logic [31:0] m_data;
  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .core_valid(core_valid), .core_reg(core_reg), .core_data(core_data), .core_ready(core_ready),
    .dbg_valid(dbg_valid), .dbg_reg(dbg_reg), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .pc_write_err(pc_write_err), .starve_cnt(starve_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit h, input bit cv, input logic [3:0] cr, input logic [31:0] cd,
                       input bit dv, input logic [3:0] dr, input logic [31:0] dd);
    hold = h; core_valid = cv; core_reg = cr; core_data = cd;
    dbg_valid = dv; dbg_reg = dr; dbg_data = dd;
  endtask
  task automatic model_reset();
    m_cnt = 0; m_known = 1; m_reg = '0; m_data = '0;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, ".wen"}, rf_write_en, 0);
    chk({tag, ".err"}, pc_write_err, 0);
    chk({tag, ".core_ready"}, core_ready, 0);
    chk({tag, ".dbg_ready"}, dbg_ready, 0);
    chk({tag, ".reg"}, rf_write_reg, 0);
    chk({tag, ".data"}, rf_write_data, 0);
    chk({tag, ".starve"}, starve_cnt, 0);
  endtask
  // One clock: inputs already driven in the low phase; readies checked before the edge, registered outputs after it.
  task automatic tick(input string tag);
    bit gc, gd, acc, pc;
    logic [3:0]  r;
    logic [31:0] d;
    #1;
    gc = 0; gd = 0;
    if (!hold) begin
      if (core_valid && dbg_valid) begin
        if (m_cnt < 4) gc = 1; else gd = 1;
      end else begin
        gc = core_valid; gd = dbg_valid;
      end
    end
    chk({tag, ".core_ready"}, core_ready, gc);
    chk({tag, ".dbg_ready"}, dbg_ready, gd);
    r = gd ? dbg_reg : core_reg;
    d = gd ? dbg_data : core_data;
    acc = gc || gd;
    pc = acc && r == 4'd15;
    if (!hold) m_cnt = (core_valid && dbg_valid && m_cnt < 4) ? m_cnt + 1 : 0;
    @(posedge clk);
    #1;
    chk({tag, ".wen"}, rf_write_en, acc && !pc);
    chk({tag, ".err"}, pc_write_err, pc);
    if (acc && !pc) begin
      m_reg = r; m_data = d; m_known = 1;
    end else if (pc) m_known = 0;
    if (m_known) begin
      chk({tag, ".reg"}, rf_write_reg, m_reg);
      chk({tag, ".data"}, rf_write_data, m_data);
    end
    chk({tag, ".starve"}, starve_cnt, 64'(m_cnt));
    @(negedge clk);
  endtask
  initial begin
    int starve_exp[6];
    starve_exp = '{1, 2, 3, 4, 0, 1};
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1 reset_checks("rst0");
    @(negedge clk);
    rst_n = 1;
    drive(0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0);
    tick("single");
    chk("single.data_explicit", rf_write_data, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("single_after");
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 4'd1, 32'hC0DE_0000 + i, 1, 4'd2, 32'hDB60_0000 + i);
      tick($sformatf("starve%0d", i));
      chk($sformatf("starve%0d.cnt_explicit", i), starve_cnt, 64'(starve_exp[i]));
      chk($sformatf("starve%0d.winner", i), rf_write_data,
          (i == 4) ? 32'hDB60_0004 : 32'hC0DE_0000 + i);
    end
    drive(0, 0, 0, 0, 1, 4'd15, 32'h1);
    tick("pc");
    chk("pc.err_explicit", pc_write_err, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("pc_after");
    drive(0, 1, 4'd4, 32'h4444, 1, 4'd6, 32'h6666);
    tick("pre_hold");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'd4, 32'h4444, 1, 4'd6, 32'h6666);
      tick($sformatf("hold%0d", i));
      chk($sformatf("hold%0d.cnt_explicit", i), starve_cnt, 1);
    end
    drive(0, 1, 4'd4, 32'h4444, 1, 4'd6, 32'h6666);
    tick("hold_release");
    chk("hold_release.core", rf_write_data, 32'h4444);
    drive(0, 1, 4'd5, 32'h5555, 0, 0, 0);
    tick("rst_mid");
    rst_n = 0;
    model_reset();
    #1 reset_checks("rst_mid");
    @(negedge clk);
    rst_n = 1;
    drive(0, 1, 4'd9, 32'h9999, 0, 0, 0);
    tick("first_after_rst");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'd1, 32'h100 + i, 1, 4'd2, 32'h200 + i);
      tick($sformatf("fill%0d", i));
    end
    chk("same.cnt4", starve_cnt, 4);
    drive(0, 1, 4'd7, 32'hAAAA_AAAA, 1, 4'd7, 32'hBBBB_BBBB);
    tick("same0");
    chk("same0.dbg_first", rf_write_data, 32'hBBBB_BBBB);
    drive(0, 1, 4'd7, 32'hAAAA_AAAA, 0, 0, 0);
    tick("same1");
    chk("same1.core_second", rf_write_data, 32'hAAAA_AAAA);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) begin
        rst_n = 0;
        model_reset();
        #1 reset_checks("rnd_rst");
        @(negedge clk);
        rst_n = 1;
      end
      drive($urandom_range(3) == 0, $urandom_range(3) != 0, 4'($urandom), $urandom,
            $urandom_range(2) != 0, 4'($urandom), $urandom);
      tick("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
